// File: rtl/msg_sequencer_pkg.sv
// Shared definitions for the message sequencer: FSM state encoding and the
// default message length, which must match the contents of the message ROM.
package msg_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam int MSG_LEN_DEFAULT = 39;

endpackage

// File: rtl/msg_sequencer.sv
// Walks a registered message ROM from index 0 to MSG_LEN-1 and offers each
// byte to a UART transmitter over a valid/ready handshake, once per start.
module msg_sequencer
  import msg_sequencer_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int INDEX_W = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [INDEX_W-1:0] o_index,
  input  logic [7:0]         i_rom_data,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  // The index register must be able to reach the last message byte.
  if (MSG_LEN < 1 || MSG_LEN > (1 << INDEX_W)) begin : g_bad_params
    $error("msg_sequencer: MSG_LEN must be in 1..2**INDEX_W");
  end

  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(MSG_LEN - 1);

  state_t             state, state_next;
  logic [INDEX_W-1:0] index_next;
  logic [7:0]         data_next;
  logic               valid_next;
  logic               done_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_index    <= '0;
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_next;
      o_index    <= index_next;
      o_tx_data  <= data_next;
      o_tx_valid <= valid_next;
      o_done     <= done_next;
    end
  end

  // ADDR gives the ROM its one cycle of read latency before LOAD samples it.
  always_comb begin
    state_next = state;
    index_next = o_index;
    data_next  = o_tx_data;
    valid_next = o_tx_valid;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          index_next = '0;
          state_next = ADDR;
        end
      end
      ADDR: state_next = LOAD;
      LOAD: begin
        data_next  = i_rom_data;
        valid_next = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (o_tx_valid && i_tx_ready) begin
          valid_next = 1'b0;
          if (o_index == LAST_INDEX) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            index_next = o_index + INDEX_W'(1);
            state_next = ADDR;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_msg_sequencer.sv
// Self-checking bench for msg_sequencer: cycle vectors for the opening bytes,
// then full-message scenarios against a behavioural ROM and sink.
module tb_msg_sequencer;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       tx_ready = 1'b0;
  logic [5:0] o_index;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] o_tx_data;
  logic       o_tx_valid, o_busy, o_done;

  logic       start1 = 1'b0;
  logic [5:0] index1;
  logic [7:0] rom_data1 = 8'h00;
  logic [7:0] tx_data1;
  logic       tx_valid1, busy1, done1;

  logic [7:0] rom [0:63];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  msg_sequencer u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .o_index(o_index),
    .i_rom_data(rom_data), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(tx_ready), .o_busy(o_busy), .o_done(o_done)
  );

  msg_sequencer #(.MSG_LEN(1), .INDEX_W(6)) u_dut1 (
    .i_clk(clk), .i_rst(i_rst), .i_start(start1), .o_index(index1),
    .i_rom_data(rom_data1), .o_tx_data(tx_data1), .o_tx_valid(tx_valid1),
    .i_tx_ready(1'b1), .o_busy(busy1), .o_done(done1)
  );

  // Registered ROMs: data follows the index by one clock.
  always @(posedge clk) begin
    rom_data  <= rom[o_index];
    rom_data1 <= rom[index1];
  end

  // Sink monitor: accepted bytes, done pulses and the edge each done was set.
  logic [7:0] got_q [$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (o_tx_valid && tx_ready) got_q.push_back(o_tx_data);
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearMonitor();
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic checkMessage(input string name, input int copies);
    checkOutput({name, "_bytes"}, got_q.size(), 39 * copies);
    for (int i = 0; i < got_q.size() && i < 39 * copies; i++)
      checkOutput({name, "_byte"}, got_q[i], rom[i % 39]);
  endtask

  task automatic pulseStart(output int start_edge);
    @(negedge clk);
    tx_ready = 1'b1;
    i_start = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Drives the sink until want_done done pulses have been seen. Optional
  // corner cases: stall at an index for 5 cycles, a stray start at an index,
  // and a new start raised in the done cycle.
  task automatic applyStimulus(input int want_done, input int stall_at, input int start_at,
                               input bit b2b, output int b2b_edge);
    int stalls = 0;
    bit start_used = 0;
    int b2b_n = -1;
    b2b_edge = -1;
    for (int n = 0; n < 1000 && done_cnt < want_done; n++) begin
      @(negedge clk);
      i_start = 1'b0;
      tx_ready = 1'b1;
      if (stall_at >= 0 && int'(o_index) == stall_at && stalls < 5 && (o_tx_valid || stalls > 0)) begin
        tx_ready = 1'b0;
        checkOutput("stall_data", o_tx_data, 8'h57);
        if (stalls > 0) checkOutput("stall_valid", o_tx_valid, 1);
        stalls++;
      end
      if (start_at >= 0 && !start_used && int'(o_index) == start_at && o_busy) begin
        i_start = 1'b1;
        start_used = 1;
      end
      if (b2b && b2b_n < 0 && o_done) begin
        i_start = 1'b1;
        b2b_n = n;
        b2b_edge = cyc + 1;
      end
      if (b2b_n >= 0 && n == b2b_n + 3) begin
        checkOutput("b2b_first_valid", o_tx_valid, 1);
        checkOutput("b2b_first_data", o_tx_data, 8'h48);
      end
    end
    checkOutput("done_reached", done_cnt, want_done);
    if (stall_at >= 0) checkOutput("stall_cycles", stalls, 5);
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic       rst, start, ready;
    logic [5:0] idx;
    logic       valid;
    logic [7:0] data;
    logic       busy, done;
  } vec_t;

  initial begin
    string msg;
    vec_t vecs [11];
    int s_edge, s2_edge;

    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string msg;
    vec_t vecs [11];
    int s_edge, s2_edge, dummy;

    msg = "Hello, World! Greetings from an FPGA.";
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    for (int i = 0; i < 37; i++) rom[i] = msg[i];
    rom[37] = 8'h0A;
    rom[38] = 8'h0D;

    //           rst start ready idx valid data  busy done
    vecs[0]  = '{1, 0, 0, 6'd0, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 1, 0, 6'd0, 0, 8'h00, 1, 0};
    vecs[2]  = '{0, 0, 0, 6'd0, 0, 8'h00, 1, 0};
    vecs[3]  = '{0, 0, 0, 6'd0, 1, 8'h48, 1, 0};
    vecs[4]  = '{0, 0, 0, 6'd0, 1, 8'h48, 1, 0};
    vecs[5]  = '{0, 0, 1, 6'd1, 0, 8'h48, 1, 0};
    vecs[6]  = '{0, 0, 1, 6'd1, 0, 8'h48, 1, 0};
    vecs[7]  = '{0, 0, 0, 6'd1, 1, 8'h65, 1, 0};
    vecs[8]  = '{0, 1, 0, 6'd1, 1, 8'h65, 1, 0};
    vecs[9]  = '{1, 1, 1, 6'd0, 0, 8'h00, 0, 0};
    vecs[10] = '{0, 0, 0, 6'd0, 0, 8'h00, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      i_rst = vecs[i].rst;
      i_start = vecs[i].start;
      tx_ready = vecs[i].ready;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_index", i), o_index, vecs[i].idx);
      checkOutput($sformatf("vec%0d_valid", i), o_tx_valid, vecs[i].valid);
      checkOutput($sformatf("vec%0d_data", i), o_tx_data, vecs[i].data);
      checkOutput($sformatf("vec%0d_busy", i), o_busy, vecs[i].busy);
      checkOutput($sformatf("vec%0d_done", i), o_done, vecs[i].done);
    end
    i_start = 1'b0;
    tx_ready = 1'b0;

    // Full message with an always-ready sink.
    clearMonitor();
    pulseStart(s_edge);
    applyStimulus(1, -1, -1, 0, dummy);
    checkMessage("full", 1);
    checkOutput("full_done_count", done_cnt, 1);
    checkOutput("full_latency", done_cyc - s_edge, 117);
    checkOutput("full_last_index", o_index, 38);

    // Sink stalls 5 cycles on 'W'.
    clearMonitor();
    pulseStart(s_edge);
    applyStimulus(1, 7, -1, 0, dummy);
    checkMessage("stall", 1);
    checkOutput("stall_w_count", got_q.size() > 7 ? int'(got_q[7] == 8'h57) + int'(got_q[8] == 8'h57) : 0, 1);

    // Stray start while busy is ignored.
    clearMonitor();
    pulseStart(s_edge);
    applyStimulus(1, -1, 10, 0, dummy);
    checkMessage("stray", 1);
    checkOutput("stray_done_count", done_cnt, 1);

    // Reset mid-message at index 20, then a clean restart.
    clearMonitor();
    pulseStart(s_edge);
    for (int n = 0; n < 200 && !(o_index == 6'd20 && o_tx_valid); n++) @(negedge clk);
    checkOutput("rst_reached_20", o_index, 20);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    checkOutput("rst_valid", o_tx_valid, 0);
    checkOutput("rst_index", o_index, 0);
    checkOutput("rst_busy", o_busy, 0);
    repeat (10) @(negedge clk);
    checkOutput("rst_no_done", done_cnt, 0);
    clearMonitor();
    pulseStart(s_edge);
    applyStimulus(1, -1, -1, 0, dummy);
    checkMessage("after_rst", 1);

    // Back-to-back messages: start raised during the done cycle.
    clearMonitor();
    pulseStart(s_edge);
    applyStimulus(2, -1, -1, 1, s2_edge);
    checkMessage("b2b", 2);
    checkOutput("b2b_second_latency", done_cyc - s2_edge, 117);

    // Single-byte message instance.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    checkOutput("len1_load_valid", tx_valid1, 0);
    @(negedge clk);
    checkOutput("len1_valid", tx_valid1, 1);
    checkOutput("len1_data", tx_data1, 8'h48);
    checkOutput("len1_done_early", done1, 0);
    @(negedge clk);
    checkOutput("len1_done", done1, 1);
    checkOutput("len1_busy", busy1, 0);
    checkOutput("len1_index", index1, 0);
    @(negedge clk);
    checkOutput("len1_done_pulse", done1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
